// File: rtl/rsp_burst_diff_sat.sv
// Burst-parallel lag-k differentiator with symmetric saturation.
// Each beat carries BURST_LEN samples (lane 0 oldest). y[n] = x[n] - x[n-k],
// k latched per frame, clamped to +/-(2^(DW-1)-1). Two-stage pipeline
// (subtract, saturate) that stalls as a whole under output backpressure.
module rsp_burst_diff_sat #(
   parameter int BURST_LEN = 8,
   parameter int DW        = 16,
   parameter int MAX_LAG   = 4,
   parameter int FRAME_LEN = 1024,
   parameter int LAG_W     = $clog2(MAX_LAG + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [LAG_W-1:0]        i_lag,
   input  logic [BURST_LEN*DW-1:0] i_data,
   input  logic                    i_valid,
   input  logic                    i_last,
   output logic                    i_ready,
   output logic [BURST_LEN*DW-1:0] o_data,
   output logic                    o_valid,
   output logic                    o_last,
   input  logic                    o_ready,
   output logic [BURST_LEN-1:0]    o_sat_mask,
   output logic [15:0]             o_sat_cnt,
   output logic                    o_frame_err
);

   localparam int FRAME_BEATS = FRAME_LEN / BURST_LEN;
   localparam int CNT_W       = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_BEATS - 1);
   localparam logic signed [DW:0] POS_LIM = {2'b00, {(DW-1){1'b1}}};
   localparam logic signed [DW:0] NEG_LIM = -POS_LIM;

   // Out-of-range lag requests (0 or above MAX_LAG) fall back to lag 1.
   function automatic logic [LAG_W-1:0] lag_fix(input logic [LAG_W-1:0] lag);
      if ((lag == '0) || (int'(lag) > MAX_LAG)) return LAG_W'(1);
      return lag;
   endfunction

   // Symmetric clamp; MSB of the result is the "clamped" flag.
   function automatic logic [DW:0] sat_sym(input logic signed [DW:0] d);
      logic [DW:0] r;
      if (d > POS_LIM)      r = {1'b1, POS_LIM[DW-1:0]};
      else if (d < NEG_LIM) r = {1'b1, NEG_LIM[DW-1:0]};
      else                  r = {1'b0, d[DW-1:0]};
      return r;
   endfunction

   // Adds the popcount of a lane mask to a 16-bit counter that sticks at 0xFFFF.
   function automatic logic [15:0] cnt_add(input logic [15:0] base,
                                           input logic [BURST_LEN-1:0] mask);
      logic [16:0] sum;
      sum = {1'b0, base};
      for (int j = 0; j < BURST_LEN; j++) sum = sum + 17'(mask[j]);
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   logic en, acc;
   assign en      = o_ready | ~o_valid;
   assign i_ready = en;
   assign acc     = i_valid & en;

   // Frame/control state
   logic                 sof;
   logic [LAG_W-1:0]     lag_q;
   logic [CNT_W-1:0]     beat_cnt;
   logic signed [DW-1:0] hist [MAX_LAG];

   // Stage 0 combinational results
   logic [LAG_W-1:0]     lag_eff;
   logic signed [DW-1:0] ext [MAX_LAG+BURST_LEN];
   logic signed [DW:0]   diff_p0 [BURST_LEN];
   logic                 cnt_end, frame_end, len_err;

   // Stage 1 registers
   logic                 vld_p1, last_p1, err_p1, sof_p1;
   logic signed [DW:0]   diff_p1 [BURST_LEN];

   // Stage 2 combinational results
   logic [DW:0]             sat_res [BURST_LEN];
   logic [BURST_LEN*DW-1:0] sat_data_p1;
   logic [BURST_LEN-1:0]    sat_mask_p1;
   logic [15:0]             cnt_next_p1;

   // Stage 0: pick the lag, line up history with the current lanes, subtract.
   always_comb begin
      lag_eff = sof ? lag_fix(i_lag) : lag_q;
      for (int m = 0; m < MAX_LAG; m++) ext[m] = hist[m];
      for (int j = 0; j < BURST_LEN; j++) ext[MAX_LAG+j] = i_data[j*DW +: DW];
      for (int j = 0; j < BURST_LEN; j++) begin
         diff_p0[j] = '0;
         for (int kk = 1; kk <= MAX_LAG; kk++) begin
            if (lag_eff == LAG_W'(kk))
               diff_p0[j] = $signed({ext[MAX_LAG+j][DW-1], ext[MAX_LAG+j]})
                          - $signed({ext[MAX_LAG+j-kk][DW-1], ext[MAX_LAG+j-kk]});
         end
         // No differencing across a frame boundary.
         if (sof && (j < int'(lag_eff))) diff_p0[j] = '0;
      end
      cnt_end   = (beat_cnt == LAST_BEAT);
      frame_end = i_last | cnt_end;
      len_err   = i_last ^ cnt_end;
   end

   // Frame tracking: lag latch, beat counter, SOF flag and sample history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sof      <= 1'b1;
         lag_q    <= LAG_W'(1);
         beat_cnt <= '0;
         for (int m = 0; m < MAX_LAG; m++) hist[m] <= '0;
      end else if (acc) begin
         sof      <= frame_end;
         lag_q    <= lag_eff;
         beat_cnt <= frame_end ? '0 : beat_cnt + CNT_W'(1);
         for (int m = 0; m < MAX_LAG; m++) hist[m] <= ext[BURST_LEN+m];
      end
   end

   // ---- stage 0 -> stage 1 boundary ----
   // Stage 1 control: valid and per-beat frame flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
         err_p1  <= 1'b0;
         sof_p1  <= 1'b0;
      end else if (en) begin
         vld_p1 <= i_valid;
         if (i_valid) begin
            last_p1 <= frame_end;
            err_p1  <= len_err;
            sof_p1  <= sof;
         end
      end
   end

   // Stage 1 data: wide differences, loaded only on accepted beats.
   always_ff @(posedge clk) begin
      if (acc) diff_p1 <= diff_p0;
   end

   // Stage 1 -> 2 combinational: clamp each lane and update the frame count.
   always_comb begin
      sat_data_p1 = '0;
      sat_mask_p1 = '0;
      for (int j = 0; j < BURST_LEN; j++) begin
         sat_res[j]                = sat_sym(diff_p1[j]);
         sat_data_p1[j*DW +: DW]   = sat_res[j][DW-1:0];
         sat_mask_p1[j]            = sat_res[j][DW];
      end
      cnt_next_p1 = cnt_add(sof_p1 ? 16'h0000 : o_sat_cnt, sat_mask_p1);
   end

   // ---- stage 1 -> stage 2 boundary ----
   // Stage 2: registered outputs; everything holds while the pipeline is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid     <= 1'b0;
         o_last      <= 1'b0;
         o_frame_err <= 1'b0;
         o_data      <= '0;
         o_sat_mask  <= '0;
         o_sat_cnt   <= '0;
      end else if (en) begin
         o_valid     <= vld_p1;
         o_last      <= vld_p1 & last_p1;
         o_frame_err <= vld_p1 & err_p1;
         if (vld_p1) begin
            o_data     <= sat_data_p1;
            o_sat_mask <= sat_mask_p1;
            o_sat_cnt  <= cnt_next_p1;
         end
      end
   end

endmodule

// File: tb/tb_rsp_burst_diff_sat.sv
// Bench for rsp_burst_diff_sat: directed frames plus randomized traffic,
// checked beat-by-beat against a sample-level reference model.
module tb_rsp_burst_diff_sat;

   localparam int BL    = 8;
   localparam int DW    = 16;
   localparam int LAG_W = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [LAG_W-1:0]  i_lag = '0;
   logic [BL*DW-1:0]  i_data = '0;
   logic              i_valid = 1'b0;
   logic              i_last = 1'b0;
   logic              i_ready;
   logic [BL*DW-1:0]  o_data;
   logic              o_valid;
   logic              o_last;
   logic              o_ready = 1'b1;
   logic [BL-1:0]     o_sat_mask;
   logic [15:0]       o_sat_cnt;
   logic              o_frame_err;

   rsp_burst_diff_sat #(.BURST_LEN(BL), .DW(DW), .MAX_LAG(4), .FRAME_LEN(1024)) dut (
      .clk(clk), .rst_n(rst_n), .i_lag(i_lag), .i_data(i_data), .i_valid(i_valid),
      .i_last(i_last), .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid),
      .o_last(o_last), .o_ready(o_ready), .o_sat_mask(o_sat_mask),
      .o_sat_cnt(o_sat_cnt), .o_frame_err(o_frame_err));

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;
   bit rdy_random = 1'b0;
   bit gap_en     = 1'b0;

   typedef struct {
      logic [127:0] d;
      logic [7:0]   m;
      logic         l;
      logic         e;
      logic [15:0]  c;
      int           acc;
      bit           lat;
   } exp_t;

   exp_t expq[$];
   exp_t me;

   logic [127:0] logd[$];
   logic [7:0]   logm[$];
   logic         logl[$];
   logic         loge[$];
   logic [15:0]  logc[$];

   // reference model state: samples of the current frame
   int fs[$];
   int fbeat = 0;
   bit msof  = 1'b1;
   int mlag  = 1;
   int mcnt  = 0;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int lane(input logic [127:0] d, input int j);
      logic signed [15:0] t;
      t = d[j*16 +: 16];
      return int'(t);
   endfunction

   function automatic void model_reset();
      fs.delete();
      fbeat = 0;
      msof  = 1'b1;
      mlag  = 1;
      mcnt  = 0;
   endfunction

   // y[n] = x[n] - x[n-k] within the frame, 0 where x[n-k] precedes the frame.
   function automatic void model_accept();
      exp_t e;
      int x, d, k, n, pc;
      bit ce;
      logic signed [15:0] v;
      if (msof) begin
         k = int'(i_lag);
         mlag = (k == 0 || k > 4) ? 1 : k;
         fs.delete();
         fbeat = 0;
         mcnt  = 0;
      end
      e.d = '0;
      e.m = '0;
      pc  = 0;
      for (int j = 0; j < BL; j++) begin
         v = i_data[j*16 +: 16];
         x = int'(v);
         n = fs.size();
         fs.push_back(x);
         if (n - mlag < 0) d = 0;
         else d = x - fs[n-mlag];
         if (d > 32767) begin d = 32767; e.m[j] = 1'b1; pc++; end
         else if (d < -32767) begin d = -32767; e.m[j] = 1'b1; pc++; end
         e.d[j*16 +: 16] = d[15:0];
      end
      mcnt = mcnt + pc;
      if (mcnt > 65535) mcnt = 65535;
      e.c   = mcnt[15:0];
      ce    = (fbeat == 127);
      e.l   = i_last | ce;
      e.e   = i_last ^ ce;
      fbeat++;
      msof  = e.l;
      e.acc = cyc;
      e.lat = !rdy_random;
      expq.push_back(e);
   endfunction

   // downstream ready: always 1 or random 50%
   always @(posedge clk) begin
      #1;
      o_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // compare process: every valid output cycle against the model, plus stall stability
   logic [127:0] hd;
   logic [7:0]   hm;
   logic         hl, he;
   bit           hv = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         expq.delete();
         model_reset();
         hv = 1'b0;
      end else begin
         if (hv)
            chk("stall_hold", {o_frame_err, o_last, o_sat_mask, o_data}, {he, hl, hm, hd});
         hv = o_valid && !o_ready;
         hd = o_data; hm = o_sat_mask; hl = o_last; he = o_frame_err;
         if (o_valid) begin
            if (expq.size() == 0) begin
               nchk++;
               nerr++;
               $display("FAIL spurious_beat: got o_valid=1 expected no pending beat (t=%0t)", $time);
            end else begin
               me = expq[0];
               chk("beat", {o_frame_err, o_last, o_sat_cnt, o_sat_mask, o_data},
                           {me.e, me.l, me.c, me.m, me.d});
               if (o_ready) begin
                  if (me.lat) chk("latency", cyc - me.acc, 2);
                  logd.push_back(o_data);
                  logm.push_back(o_sat_mask);
                  logl.push_back(o_last);
                  loge.push_back(o_frame_err);
                  logc.push_back(o_sat_cnt);
                  void'(expq.pop_front());
               end
            end
         end
         if (i_valid && i_ready) model_accept();
      end
   end

   task automatic clear_logs();
      logd.delete(); logm.delete(); logl.delete(); loge.delete(); logc.delete();
   endtask

   task automatic send(input logic [127:0] d, input bit last, input int lag);
      int t = 0;
      bit ok = 1'b0;
      i_data  = d;
      i_last  = last;
      i_lag   = lag[2:0];
      i_valid = 1'b1;
      while (!ok && t < 200) begin
         @(negedge clk);
         ok = i_ready;
         @(posedge clk);
         #1;
         t++;
      end
      if (!ok) begin
         nchk++;
         nerr++;
         $display("FAIL send_timeout: got no i_ready in %0d cycles expected acceptance", t);
      end
      i_valid = 1'b0;
      i_last  = 1'b0;
      if (gap_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
   endtask

   // mode 0: ramp x[n]=step*n, 1: alternating +32767/-32768, 2: random
   task automatic send_frame(input int nb, input bit with_last, input int lag0,
                             input int lag1, input int mode, input int step);
      logic [127:0] d;
      int v, n;
      for (int b = 0; b < nb; b++) begin
         for (int j = 0; j < BL; j++) begin
            n = b * BL + j;
            case (mode)
               0:       v = step * n;
               1:       v = (n % 2 == 0) ? 32767 : -32768;
               default: v = int'($urandom);
            endcase
            d[j*16 +: 16] = v[15:0];
         end
         send(d, with_last && (b == nb - 1), (b < nb / 2) ? lag0 : lag1);
      end
   endtask

   task automatic drain();
      int t = 0;
      while (expq.size() != 0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (expq.size() != 0) begin
         nchk++;
         nerr++;
         $display("FAIL drain_timeout: got %0d beats pending expected 0", expq.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {o_valid, o_last, o_frame_err, o_sat_mask, o_sat_cnt, o_data}, '0);
      chk("reset_ready", i_ready, 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // lag-1 ramp
      clear_logs();
      send_frame(128, 1'b1, 1, 1, 0, 1);
      drain();
      chk("ramp_count", logd.size(), 128);
      if (logd.size() >= 128) begin
         chk("ramp_sof_l0", lane(logd[0], 0), 0);
         chk("ramp_sof_l1", lane(logd[0], 1), 1);
         chk("ramp_b5_l0", lane(logd[5], 0), 1);
         chk("ramp_last", {logl[127], loge[127], logc[127]}, {1'b1, 1'b0, 16'd0});
      end

      // lag switch: A with k=2 (mid-frame request for 4 ignored), then B with k=4
      clear_logs();
      send_frame(128, 1'b1, 2, 4, 0, 3);
      send_frame(128, 1'b1, 4, 4, 0, 3);
      drain();
      chk("lag_count", logd.size(), 256);
      if (logd.size() >= 256) begin
         chk("lagA_sof_l1", lane(logd[0], 1), 0);
         chk("lagA_sof_l2", lane(logd[0], 2), 6);
         chk("lagA_b100_l0", lane(logd[100], 0), 6);
         chk("lagB_sof_l3", lane(logd[128], 3), 0);
         chk("lagB_sof_l4", lane(logd[128], 4), 12);
         chk("lagB_b1_l0", lane(logd[129], 0), 12);
      end

      // saturation
      clear_logs();
      send_frame(128, 1'b1, 1, 1, 1, 0);
      drain();
      chk("sat_count", logd.size(), 128);
      if (logd.size() >= 128) begin
         chk("sat_sof_mask", logm[0], 8'hFE);
         chk("sat_sof_l1", lane(logd[0], 1), -32767);
         chk("sat_b1_mask", logm[1], 8'hFF);
         chk("sat_b1_l0", lane(logd[1], 0), 32767);
         chk("sat_cnt_end", logc[127], 16'd1023);
      end

      // backpressure with gaps
      clear_logs();
      rdy_random = 1'b1;
      gap_en     = 1'b1;
      send_frame(128, 1'b1, 3, 3, 0, 5);
      drain();
      rdy_random = 1'b0;
      gap_en     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("bp_count", logd.size(), 128);

      // frame length: short frame, then long frame with no i_last
      clear_logs();
      send_frame(64, 1'b1, 1, 1, 0, 1);
      send_frame(130, 1'b0, 1, 1, 0, 1);
      drain();
      chk("len_count", logd.size(), 194);
      if (logd.size() >= 194) begin
         chk("short_end", {logl[63], loge[63], logl[62]}, 3'b110);
         chk("long_end", {logl[191], loge[191], logl[190]}, 3'b110);
         chk("long_next_sof_l0", lane(logd[192], 0), 0);
         chk("long_next_l1", lane(logd[192], 1), 1);
      end

      // reset mid-frame at beat 40
      send_frame(41, 1'b0, 2, 2, 0, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", {o_valid, o_sat_cnt}, '0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_logs();
      send_frame(128, 1'b1, 2, 2, 0, 7);
      drain();
      chk("rst_count", logd.size(), 128);
      if (logd.size() >= 128) begin
         chk("rst_sof_l0", lane(logd[0], 0), 0);
         chk("rst_sof_l1", lane(logd[0], 1), 0);
         chk("rst_sof_l2", lane(logd[0], 2), 14);
      end

      // randomized frames: random data, lags (incl. out-of-range), lengths, gaps, ready
      rdy_random = 1'b1;
      gap_en     = 1'b1;
      for (int f = 0; f < 6; f++) begin
         int kind;
         kind = int'($urandom_range(0, 2));
         if (kind == 0)
            send_frame(int'($urandom_range(1, 127)), 1'b1, int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 7)), 2, 0);
         else
            send_frame(128, kind == 1, int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 7)), 2, 0);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
